lsmitll_ndro_word: RTL

Clocked, cycle-level model of a WIDTH-bit RSFQ non-destructive-readout (NDRO) storage word with a DFF output pipeline. It is the consumer stage for constant-source and pulse-generator cells: their pulse outputs drive its set/clear inputs. It stores state across reads and emits stored bits as output pulses on read strobes. Set/clear collisions are flagged rather than silently resolved.

---
 rtl/lsmitll_ndro_pkg.sv | 24 ++
 rtl/lsmitll_ndro_bit.sv | 25 ++
 rtl/lsmitll_ndro_word.sv | 74 +++++++
 3 files changed

// File: rtl/lsmitll_ndro_pkg.sv
// Shared limits and helpers for the NDRO storage word.
// Parameter legality and the saturating counter step live here so every user agrees.
package lsmitll_ndro_pkg;

   localparam int MAX_WIDTH   = 32;
   localparam int MAX_LATENCY = 8;
   localparam int MAX_CNT_W   = 16;

   // Increment value, holding at 2^width-1 instead of wrapping.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                    input int unsigned width);
      logic [MAX_CNT_W:0] lim;
      lim = ((MAX_CNT_W+1)'(1) << width) - (MAX_CNT_W+1)'(1);
      if ({1'b0, value} >= lim) return value;
      return value + 1'b1;
   endfunction

   function automatic bit params_ok(input int width, input int latency, input int cnt_w);
      return (width >= 1) && (width <= MAX_WIDTH) &&
             (latency >= 1) && (latency <= MAX_LATENCY) &&
             (cnt_w >= 1) && (cnt_w <= MAX_CNT_W);
   endfunction

endpackage

// File: rtl/lsmitll_ndro_bit.sv
// One NDRO storage bit: set on a, clear on b, hold on idle or collision.
// coll is purely combinational and reflects the current cycle's inputs.
module lsmitll_ndro_bit
   import lsmitll_ndro_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   output logic s,
   output logic coll
);

   assign coll = a & b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         s <= 1'b0;
      else if (a && !b)
         s <= 1'b1;
      else if (!a && b)
         s <= 1'b0;
   end

endmodule

// File: rtl/lsmitll_ndro_word.sv
// WIDTH-bit NDRO word with a LATENCY-deep DFF read pipeline and
// a sticky collision flag plus saturating collision-cycle counter.
module lsmitll_ndro_word
   import lsmitll_ndro_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd,
   output logic [WIDTH-1:0] q,
   output logic             q_vld,
   output logic             viol,
   output logic [CNT_W-1:0] viol_cnt
);

   if (!params_ok(WIDTH, LATENCY, CNT_W)) begin : g_bad_params
      $error("lsmitll_ndro_word: parameter out of range");
   end

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] coll;
   logic             any_coll;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      lsmitll_ndro_bit u_bit (
         .clk  (clk),
         .rst  (rst),
         .a    (a[i]),
         .b    (b[i]),
         .s    (s[i]),
         .coll (coll[i])
      );
   end

   assign any_coll = |coll;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         viol     <= 1'b0;
         viol_cnt <= '0;
      end else if (any_coll) begin
         viol     <= 1'b1;
         viol_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(viol_cnt), CNT_W));
      end
   end

   // Stage 0 samples s before this edge's set/clear lands (read-before-write);
   // invalid stages carry zero so q never pulses without q_vld.
   logic [WIDTH-1:0] pipe_data [LATENCY];
   logic [LATENCY-1:0] pipe_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
         pipe_vld <= '0;
      end else begin
         pipe_data[0] <= rd ? s : '0;
         pipe_vld[0]  <= rd;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_vld[i]  <= pipe_vld[i-1];
         end
      end
   end

   assign q     = pipe_data[LATENCY-1];
   assign q_vld = pipe_vld[LATENCY-1];

endmodule
